// File: rtl/uart_tx_fifo.sv
// Byte-buffered 8N1 UART transmitter: a small FIFO feeds a START/DATA/STOP
// serialiser, and back-to-back frames follow each other with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = 16;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       shift;
    logic [TMR_W-1:0] timer;
    logic [2:0]       bit_idx;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             fifo_empty;

    assign fifo_empty = (count == '0);
    assign ready      = (count != FULL_CNT);
    assign push       = data_valid && ready;
    assign bit_end    = (timer == TMR_LAST);
    // Pop only when the serialiser is about to load a new byte.
    assign pop        = !fifo_empty &&
                        ((state == S_IDLE) || (state == S_STOP && bit_end));
    assign busy       = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (data_valid && !ready) begin
                overflow <= 1'b1;
            end
        end
    end

    // tx is registered and updated together with the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            shift   <= '0;
            timer   <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx    <= 1'b1;
                    timer <= '0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= S_DATA;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        timer <= '0;
                        shift <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        timer <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            tx    <= 1'b0;
                            state <= S_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434: clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer depth; power of two, 2..16.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data_in  input  8  byte to transmit, sampled when accepted.
REQ-006 data_valid  input  1  upstream byte-valid strobe, level-sensitive per cycle.
REQ-007 ready  output  1  high when the FIFO can accept a byte this cycle.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 busy  output  1  high while a frame is on the line or the FIFO is non-empty.
REQ-010 overflow  output  1  sticky flag: a byte was offered while the FIFO was full.

Function
REQ-011 Frame format SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-012 ready SHALL equal NOT full; it is combinational from the FIFO count only, not from data_valid.
REQ-013 A byte SHALL be accepted (written to FIFO tail) on any edge where data_valid=1 and ready=1.
REQ-014 data_valid=1 with ready=0 SHALL drop the byte, leave FIFO unchanged, and set overflow=1.
REQ-015 overflow SHALL remain 1 until reset.
REQ-016 A push and pop on the same edge SHALL leave the count unchanged and keep byte order.
REQ-017 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-018 State machine: IDLE, START, DATA, STOP.
REQ-019 IDLE: tx=1; if FIFO non-empty, next edge pops head into the shift register, clears the bit timer, and enters START.
REQ-020 START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-021 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right after each bit; after bit index 7, enter STOP.
REQ-022 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, if FIFO non-empty, pop and enter START on the same edge (no idle gap), else enter IDLE.
REQ-023 Latency: tx SHALL go low on the first rising edge after the accept edge when in IDLE with an empty FIFO.
REQ-024 A frame in progress SHALL never be altered by pushes or overflow events.
REQ-025 busy SHALL be 1 in START, DATA, and STOP, or when count>0; else 0.
REQ-026 Bit timer SHALL count 0..CLKS_PER_BIT-1 and be wide enough for the maximum parameter value.

Reset
REQ-027 While rst_n=0: state=IDLE, tx=1, busy=0, overflow=0, FIFO empty (ready=1), shift register, timer, and bit index all 0.
REQ-028 Reset asserted mid-frame SHALL abort immediately (tx=1 asynchronously) and discard all buffered bytes.
REQ-029 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Push 0xA5 from idle -> tx low 1 cycle later, then bits 1,0,1,0,0,1,0,1, then 1; each held 4 cycles; 40-cycle frame; then busy=0.
REQ-031 Push 0x00,0xFF,0x55 back-to-back -> three contiguous 40-cycle frames with no idle cycles between them, in push order.
REQ-032 Hold data_valid=1 for 6 cycles from idle (bytes 1..6) -> bytes 1..5 accepted (one popped, four buffered), ready=0, byte 6 dropped, overflow=1; tx carries 1..5.
REQ-033 Push while count=4 on the same edge as a STOP-end pop -> push rejected (ready=0), overflow=1, count becomes 3.
REQ-034 Assert rst_n=0 during data bit 3 of a frame with 2 bytes queued -> tx=1 immediately, busy=0, ready=1, overflow=0; no further frames after release.
REQ-035 Random bytes at random data_valid gaps for 1000 bytes -> a reference UART receiver model decodes an identical sequence; overflow stays 0 when ready is respected.
